// File: rtl/mult8_pkg.sv
// -----------------------------------------------------------------------------
// mult8_pkg
// Shared definitions for the control unit of the 8-bit ROM-based split
// multiplier: state encoding, ROM-address and sum-step select codes, and the
// nominal START-to-DONE latencies with and without ROM wait states.
// Optional feature macro seen by users of this package: MULT_UC_ROM_WAIT_EN.
// -----------------------------------------------------------------------------
package mult8_pkg;

  localparam int unsigned STATE_W = 5;
  localparam int unsigned HOLD_W  = 4;

  // Wait states W1..W3 are always encoded so both builds share one encoding;
  // they are only reachable when MULT_UC_ROM_WAIT_EN is defined.
  typedef enum logic [STATE_W-1:0] {
    S_IDLE    = 5'd0,
    S_CLEAR   = 5'd1,
    S_LOADXY  = 5'd2,
    S_DE0     = 5'd3,
    S_ROM1    = 5'd4,
    S_W1      = 5'd5,
    S_LDA     = 5'd6,
    S_ROM2    = 5'd7,
    S_W2      = 5'd8,
    S_LDB     = 5'd9,
    S_ROM3    = 5'd10,
    S_W3      = 5'd11,
    S_LDDE1   = 5'd12,
    S_SOMA1   = 5'd13,
    S_LDAB    = 5'd14,
    S_SOMA2   = 5'd15,
    S_LDSHIFT = 5'd16,
    S_SOMA3   = 5'd17,
    S_FIM     = 5'd18
  } state_e;

  // ROM address select codes
  localparam logic [1:0] SEL_NONE = 2'd0;
  localparam logic [1:0] SEL_LO   = 2'd1;
  localparam logic [1:0] SEL_HI   = 2'd2;
  localparam logic [1:0] SEL_DE   = 2'd3;

  // Result mux / sum step codes
  localparam logic [1:0] SOMA_NONE = 2'd0;
  localparam logic [1:0] SOMA_1    = 2'd1;
  localparam logic [1:0] SOMA_2    = 2'd2;
  localparam logic [1:0] SOMA_3    = 2'd3;

  // Cycle index (START sampled at edge 0) of the first DONE cycle
  localparam int unsigned LAT_NOWAIT = 15;
  localparam int unsigned LAT_WAIT   = 18;

endpackage

// File: rtl/uc_multiplier8bits.sv
// -----------------------------------------------------------------------------
// uc_multiplier8bits
// Control unit that sequences the 8-bit ROM-based split multiplier datapath:
// clear, X/Y load, D/E nibble sums, three ROM lookups (low, high, D*E), A/B/DE
// combine and the final shift-add. One datapath step per cycle.
//
// Parameter:
//   DONE_CYCLES    cycles DONE stays high after completion (1..15)
// Optional feature macro:
//   MULT_UC_ROM_WAIT_EN  inserts one all-zero wait cycle after each ROM lookup
//                        so a registered ROM has time to respond.
//
// Ports:
//   CLK            in   rising-edge clock
//   RESET          in   asynchronous active-high reset
//   START          in   operation request, sampled only in IDLE
//   PRONTO_FD      in   datapath completion flag
//   CLR_FD         out  datapath synchronous clear
//   LD_XY          out  load operands
//   LD_DE0         out  compute D/E nibble sums
//   LD_A           out  capture low-nibble product
//   LD_B           out  capture high-nibble product
//   LD_DE1         out  capture D*E product
//   LD_AB          out  compute A+B and {B,A}
//   LD_DE_ABshift  out  compute (DE-(A+B))<<4
//   LD_RES         out  result-capture strobe
//   SELROM   [1:0] out  ROM address select (none/low/high/DE)
//   SELSOMA  [1:0] out  result mux / sum step
//   BUSY           out  operation in progress
//   DONE           out  result valid
// -----------------------------------------------------------------------------
module uc_multiplier8bits
  import mult8_pkg::*;
#(
  parameter int unsigned DONE_CYCLES = 1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       START,
  input  logic       PRONTO_FD,
  output logic       CLR_FD,
  output logic       LD_XY,
  output logic       LD_DE0,
  output logic       LD_A,
  output logic       LD_B,
  output logic       LD_DE1,
  output logic       LD_AB,
  output logic       LD_DE_ABshift,
  output logic       LD_RES,
  output logic [1:0] SELROM,
  output logic [1:0] SELSOMA,
  output logic       BUSY,
  output logic       DONE
);

  // Last value of the hold counter before leaving FIM
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(DONE_CYCLES - 1);

  state_e            state_q, state_d;
  logic [HOLD_W-1:0] cnt_q,   cnt_d;

  // State and DONE-hold counter registers
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and hold-counter logic
  always_comb begin
    state_d = state_q;
    cnt_d   = 4'd0;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d = S_CLEAR;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLEAR:   state_d = S_LOADXY;
      S_LOADXY:  state_d = S_DE0;
      S_DE0:     state_d = S_ROM1;
`ifdef MULT_UC_ROM_WAIT_EN
      S_ROM1:    state_d = S_W1;
      S_ROM2:    state_d = S_W2;
      S_ROM3:    state_d = S_W3;
`else
      S_ROM1:    state_d = S_LDA;
      S_ROM2:    state_d = S_LDB;
      S_ROM3:    state_d = S_LDDE1;
`endif
      S_W1:      state_d = S_LDA;
      S_LDA:     state_d = S_ROM2;
      S_W2:      state_d = S_LDB;
      S_LDB:     state_d = S_ROM3;
      S_W3:      state_d = S_LDDE1;
      S_LDDE1:   state_d = S_SOMA1;
      S_SOMA1:   state_d = S_LDAB;
      S_LDAB:    state_d = S_SOMA2;
      S_SOMA2:   state_d = S_LDSHIFT;
      S_LDSHIFT: state_d = S_SOMA3;
      S_SOMA3:   state_d = S_FIM;
      S_FIM: begin
        // Counter advances only on cycles where the datapath reports ready;
        // it is cleared on the way back to IDLE.
        if (PRONTO_FD) begin
          if (cnt_q == HOLD_LAST) begin
            state_d = S_IDLE;
            cnt_d   = 4'd0;
          end else begin
            state_d = S_FIM;
            cnt_d   = cnt_q + 4'd1;
          end
        end else begin
          state_d = S_FIM;
          cnt_d   = cnt_q;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Output decode from the state register; only FIM looks at PRONTO_FD so that
  // DONE tracks the datapath flag within the same cycle.
  always_comb begin
    CLR_FD        = 1'b0;
    LD_XY         = 1'b0;
    LD_DE0        = 1'b0;
    LD_A          = 1'b0;
    LD_B          = 1'b0;
    LD_DE1        = 1'b0;
    LD_AB         = 1'b0;
    LD_DE_ABshift = 1'b0;
    LD_RES        = 1'b0;
    SELROM        = SEL_NONE;
    SELSOMA       = SOMA_NONE;
    BUSY          = 1'b1;
    DONE          = 1'b0;
    case (state_q)
      S_IDLE:    BUSY          = 1'b0;
      S_CLEAR:   CLR_FD        = 1'b1;
      S_LOADXY:  LD_XY         = 1'b1;
      S_DE0:     LD_DE0        = 1'b1;
      S_ROM1:    SELROM        = SEL_LO;
      S_W1:      BUSY          = 1'b1;
      S_LDA:     LD_A          = 1'b1;
      S_ROM2:    SELROM        = SEL_HI;
      S_W2:      BUSY          = 1'b1;
      S_LDB:     LD_B          = 1'b1;
      S_ROM3:    SELROM        = SEL_DE;
      S_W3:      BUSY          = 1'b1;
      S_LDDE1:   LD_DE1        = 1'b1;
      S_SOMA1:   SELSOMA       = SOMA_1;
      S_LDAB:    LD_AB         = 1'b1;
      S_SOMA2:   SELSOMA       = SOMA_2;
      S_LDSHIFT: LD_DE_ABshift = 1'b1;
      S_SOMA3:   SELSOMA       = SOMA_3;
      S_FIM: begin
        BUSY   = ~PRONTO_FD;
        DONE   = PRONTO_FD;
        // Result captured once, on the first ready cycle only
        LD_RES = PRONTO_FD & (cnt_q == 4'd0);
      end
      default:   BUSY          = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_uc_multiplier8bits.sv
// -----------------------------------------------------------------------------
// tb_uc_multiplier8bits
// Directed bench for the multiplier control unit. A small datapath model
// reacts to the strobes and raises PRONTO_FD after the last sum step. A second
// instance with DONE_CYCLES=3 covers the DONE hold.
// -----------------------------------------------------------------------------
module tb_uc_multiplier8bits;
  import mult8_pkg::*;

`ifdef MULT_UC_ROM_WAIT_EN
  localparam int LAT = LAT_WAIT;
`else
  localparam int LAT = LAT_NOWAIT;
`endif

  // Observation vector layout:
  // {CLR,LD_XY,LD_DE0,LD_A,LD_B,LD_DE1,LD_AB,LD_SH,LD_RES,SELROM,SELSOMA,BUSY,DONE}
  localparam logic [14:0] E_IDLE    = 15'h0000;
  localparam logic [14:0] E_CLEAR   = 15'h4002;
  localparam logic [14:0] E_LOADXY  = 15'h2002;
  localparam logic [14:0] E_DE0     = 15'h1002;
  localparam logic [14:0] E_ROM1    = 15'h0012;
  localparam logic [14:0] E_WAIT    = 15'h0002;
  localparam logic [14:0] E_LDA     = 15'h0802;
  localparam logic [14:0] E_ROM2    = 15'h0022;
  localparam logic [14:0] E_LDB     = 15'h0402;
  localparam logic [14:0] E_ROM3    = 15'h0032;
  localparam logic [14:0] E_LDDE1   = 15'h0202;
  localparam logic [14:0] E_SOMA1   = 15'h0006;
  localparam logic [14:0] E_LDAB    = 15'h0102;
  localparam logic [14:0] E_SOMA2   = 15'h000A;
  localparam logic [14:0] E_LDSH    = 15'h0082;
  localparam logic [14:0] E_SOMA3   = 15'h000E;
  localparam logic [14:0] E_FIMDONE = 15'h0041;
  localparam logic [14:0] E_FIMHOLD = 15'h0001;
  localparam logic [14:0] E_FIMWAIT = 15'h0002;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic RESET, START, force_low, PRONTO_FD;
  logic CLR_FD, LD_XY, LD_DE0, LD_A, LD_B, LD_DE1, LD_AB, LD_DE_ABshift, LD_RES;
  logic [1:0] SELROM, SELSOMA;
  logic BUSY, DONE;

  logic START3, PRONTO3;
  logic CLR3, LDXY3, LDDE03, LDA3, LDB3, LDDE13, LDAB3, LDSH3, LDRES3;
  logic [1:0] SELROM3, SELSOMA3;
  logic BUSY3, DONE3;

  logic [14:0] obs, obs3;
  assign obs  = {CLR_FD, LD_XY, LD_DE0, LD_A, LD_B, LD_DE1, LD_AB, LD_DE_ABshift,
                 LD_RES, SELROM, SELSOMA, BUSY, DONE};
  assign obs3 = {CLR3, LDXY3, LDDE03, LDA3, LDB3, LDDE13, LDAB3, LDSH3,
                 LDRES3, SELROM3, SELSOMA3, BUSY3, DONE3};

  uc_multiplier8bits #(.DONE_CYCLES(1)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .PRONTO_FD(PRONTO_FD),
    .CLR_FD(CLR_FD), .LD_XY(LD_XY), .LD_DE0(LD_DE0), .LD_A(LD_A), .LD_B(LD_B),
    .LD_DE1(LD_DE1), .LD_AB(LD_AB), .LD_DE_ABshift(LD_DE_ABshift),
    .LD_RES(LD_RES), .SELROM(SELROM), .SELSOMA(SELSOMA), .BUSY(BUSY), .DONE(DONE)
  );

  uc_multiplier8bits #(.DONE_CYCLES(3)) dut3 (
    .CLK(CLK), .RESET(RESET), .START(START3), .PRONTO_FD(PRONTO3),
    .CLR_FD(CLR3), .LD_XY(LDXY3), .LD_DE0(LDDE03), .LD_A(LDA3), .LD_B(LDB3),
    .LD_DE1(LDDE13), .LD_AB(LDAB3), .LD_DE_ABshift(LDSH3),
    .LD_RES(LDRES3), .SELROM(SELROM3), .SELSOMA(SELSOMA3), .BUSY(BUSY3), .DONE(DONE3)
  );

  // Datapath model: Karatsuba-style split multiply driven by the strobes
  localparam logic [7:0] X_OP = 8'hA7;
  localparam logic [7:0] Y_OP = 8'h3C;
  logic [7:0]  x_q, y_q, a_q, b_q;
  logic [4:0]  d_q, e_q;
  logic [9:0]  de_q;
  logic [8:0]  ab_q;
  logic [15:0] ba_q, sh_q, res_q;
  logic        pr_q;

  assign PRONTO_FD = pr_q & ~force_low;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET || CLR_FD) begin
      x_q <= 8'd0; y_q <= 8'd0; a_q <= 8'd0; b_q <= 8'd0;
      d_q <= 5'd0; e_q <= 5'd0; de_q <= 10'd0; ab_q <= 9'd0;
      ba_q <= 16'd0; sh_q <= 16'd0; res_q <= 16'd0; pr_q <= 1'b0;
    end else begin
      if (LD_XY)  begin x_q <= X_OP; y_q <= Y_OP; end
      if (LD_DE0) begin
        d_q <= {1'b0, x_q[3:0]} + {1'b0, x_q[7:4]};
        e_q <= {1'b0, y_q[3:0]} + {1'b0, y_q[7:4]};
      end
      if (LD_A)   a_q  <= {4'd0, x_q[3:0]} * {4'd0, y_q[3:0]};
      if (LD_B)   b_q  <= {4'd0, x_q[7:4]} * {4'd0, y_q[7:4]};
      if (LD_DE1) de_q <= {5'd0, d_q} * {5'd0, e_q};
      if (LD_AB)  begin ab_q <= {1'b0, a_q} + {1'b0, b_q}; ba_q <= {b_q, a_q}; end
      if (LD_DE_ABshift) sh_q <= ({6'd0, de_q} - {7'd0, ab_q}) << 4;
      if (LD_RES) res_q <= ba_q + sh_q;
      if (SELSOMA == 2'd3) pr_q <= 1'b1;
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one clock, sample 1 time unit later, check per-cycle invariants
  task automatic step();
    @(posedge CLK);
    #1;
    chk("onehot_ld", {15'd0, ($countones(obs[14:6]) <= 1)}, 16'd1);
    chk("sel_excl", {15'd0, !(obs[5:4] != 2'd0 && obs[3:2] != 2'd0)}, 16'd1);
    chk("onehot_ld3", {15'd0, ($countones(obs3[14:6]) <= 1)}, 16'd1);
    chk("sel_excl3", {15'd0, !(obs3[5:4] != 2'd0 && obs3[3:2] != 2'd0)}, 16'd1);
  endtask

  typedef struct {
    logic        start;
    logic [14:0] exp;
  } vec_t;

  vec_t        tv[$];
  logic [14:0] seq[$];
  int          first_done, res_cnt, clr_cnt, done_cnt, guard;

  initial begin
    RESET = 1'b1; START = 1'b0; force_low = 1'b0; START3 = 1'b0; PRONTO3 = 1'b1;

    // Expected sequence from CLEAR to the FIM cycle
    seq.push_back(E_CLEAR); seq.push_back(E_LOADXY); seq.push_back(E_DE0);
    seq.push_back(E_ROM1);
`ifdef MULT_UC_ROM_WAIT_EN
    seq.push_back(E_WAIT);
`endif
    seq.push_back(E_LDA); seq.push_back(E_ROM2);
`ifdef MULT_UC_ROM_WAIT_EN
    seq.push_back(E_WAIT);
`endif
    seq.push_back(E_LDB); seq.push_back(E_ROM3);
`ifdef MULT_UC_ROM_WAIT_EN
    seq.push_back(E_WAIT);
`endif
    seq.push_back(E_LDDE1); seq.push_back(E_SOMA1); seq.push_back(E_LDAB);
    seq.push_back(E_SOMA2); seq.push_back(E_LDSH);  seq.push_back(E_SOMA3);
    seq.push_back(E_FIMDONE);
    foreach (seq[k]) tv.push_back('{(k == 0), seq[k]});
    tv.push_back('{1'b0, E_IDLE});
    tv.push_back('{1'b0, E_IDLE});

    // Reset state
    #3;
    chk("reset_outputs", {1'b0, obs}, {1'b0, E_IDLE});
    chk("reset_outputs3", {1'b0, obs3}, {1'b0, E_IDLE});
    #9 RESET = 1'b0;
    step();
    chk("idle_after_reset", {1'b0, obs}, {1'b0, E_IDLE});

    // Single operation, table-driven per-cycle check
    first_done = -1; res_cnt = 0;
    for (int i = 0; i < tv.size(); i++) begin
      START = tv[i].start;
      step();
      chk($sformatf("seq[%0d]", i + 1), {1'b0, obs}, {1'b0, tv[i].exp});
      if (DONE && first_done < 0) first_done = i + 1;
      res_cnt += int'(LD_RES);
    end
    chk("first_done_cycle", 16'(first_done), 16'(LAT));
    chk("ld_res_pulses", 16'(res_cnt), 16'd1);
    chk("dp_result", res_q, 16'h2724);

    // Asynchronous reset while in LDB
    START = 1'b1;
    step();
    START = 1'b0;
    guard = 0;
    while (obs !== E_LDB && guard < 20) begin step(); guard++; end
    chk("reach_ldb", {1'b0, obs}, {1'b0, E_LDB});
    #2 RESET = 1'b1;
    #1 chk("async_reset_outputs", {1'b0, obs}, {1'b0, E_IDLE});
    #2 RESET = 1'b0;
    done_cnt = 0; clr_cnt = 0;
    for (int c = 0; c < LAT + 4; c++) begin
      step();
      done_cnt += int'(DONE);
      clr_cnt  += int'(CLR_FD);
    end
    chk("no_done_after_reset", 16'(done_cnt), 16'd0);
    chk("no_restart_after_reset", 16'(clr_cnt), 16'd0);

    // START re-asserted during BUSY is dropped
    START = 1'b1;
    step();
    START = 1'b0;
    clr_cnt = int'(CLR_FD); done_cnt = 0;
    for (int c = 1; c < LAT + 6; c++) begin
      START = (c >= 3 && c <= 10);
      step();
      clr_cnt  += int'(CLR_FD);
      done_cnt += int'(DONE);
    end
    START = 1'b0;
    chk("busy_start_one_clear", 16'(clr_cnt), 16'd1);
    chk("busy_start_one_done", 16'(done_cnt), 16'd1);
    chk("busy_start_idle", {1'b0, obs}, {1'b0, E_IDLE});

    // START held: one IDLE cycle after FIM, then the next CLEAR
    START = 1'b1;
    repeat (LAT) step();
    chk("b2b_fim", {1'b0, obs}, {1'b0, E_FIMDONE});
    step();
    chk("b2b_idle", {1'b0, obs}, {1'b0, E_IDLE});
    step();
    chk("b2b_clear", {1'b0, obs}, {1'b0, E_CLEAR});
    START = 1'b0;
    repeat (LAT + 2) step();
    chk("b2b_end_idle", {1'b0, obs}, {1'b0, E_IDLE});

    // PRONTO_FD held low for 5 FIM cycles
    force_low = 1'b1;
    START = 1'b1;
    step();
    START = 1'b0;
    repeat (LAT - 1) step();
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("fim_wait[%0d]", k), {1'b0, obs}, {1'b0, E_FIMWAIT});
      step();
    end
    force_low = 1'b0;
    #1 chk("done_on_pronto_rise", {1'b0, obs}, {1'b0, E_FIMDONE});
    step();
    chk("idle_after_wait", {1'b0, obs}, {1'b0, E_IDLE});

    // DONE_CYCLES = 3
    START3 = 1'b1;
    step();
    START3 = 1'b0;
    chk("dc3_clear", {1'b0, obs3}, {1'b0, E_CLEAR});
    repeat (LAT - 1) step();
    chk("dc3_done1", {1'b0, obs3}, {1'b0, E_FIMDONE});
    step();
    chk("dc3_done2", {1'b0, obs3}, {1'b0, E_FIMHOLD});
    step();
    chk("dc3_done3", {1'b0, obs3}, {1'b0, E_FIMHOLD});
    step();
    chk("dc3_idle", {1'b0, obs3}, {1'b0, E_IDLE});
    step();
    chk("dc3_idle2", {1'b0, obs3}, {1'b0, E_IDLE});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
